// File: rtl/fp_arb_pkg.sv
// Shared types for the FP unit arbiters.
// Holds the arbiter state encoding and the FP16 operand width.
package fp_arb_pkg;

  localparam int FP_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first active request at or after ptr wins.
// Purely combinational so the caller decides when the grant is used.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] idx;

  // Walk from the farthest slot back to ptr so the nearest one wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fp_sub_arbiter.sv
// Shares one FP16 subtract wrapper among NREQ requesters, round-robin,
// returning each result as a one-cycle pulse tagged with its owner.
module fp_sub_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = FP_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_q,
  output logic [IDW-1:0]   rsp_id,
  output logic             busy,
  output logic             fp_en,
  output logic [DW-1:0]    fp_a,
  output logic [DW-1:0]    fp_b,
  input  logic [DW-1:0]    fp_q,
  input  logic             fp_stall
);

  arb_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] op_id;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] id_hot;

  logic [DW-1:0] a_arr [NREQ];
  logic [DW-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*DW +: DW];
    assign b_arr[g] = req_b[g*DW +: DW];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (win_id)
  );

  assign next_ptr =
    (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    id_hot = '0;
    for (int i = 0; i < NREQ; i++) begin
      id_hot[i] = (op_id == IDW'(i));
    end
  end

  // Grant is only offered while idle and out of reset.
  assign req_ready =
    (state == IDLE && reset) ? grant : '0;

  assign busy = (state != IDLE);
  assign fp_a = op_a;
  assign fp_b = op_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      fp_en     <= 1'b0;
      rsp_valid <= '0;
      rsp_q     <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            op_a   <= a_arr[win_id];
            op_b   <= b_arr[win_id];
            op_id  <= win_id;
            rr_ptr <= next_ptr;
            fp_en  <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Stall length is owned by the wrapper; wait it out.
          if (!fp_stall) begin
            rsp_q     <= fp_q;
            rsp_id    <= op_id;
            rsp_valid <= id_hot;
            fp_en     <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Bench for fp_sub_arbiter: directed cases plus random traffic
// checked every cycle against a cycle-count reference model.
module tb_fp_sub_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_q;
  logic [IDW-1:0]     rsp_id;
  logic               busy;
  logic               fp_en;
  logic [DW-1:0]      fp_a;
  logic [DW-1:0]      fp_b;
  logic [DW-1:0]      fp_q;
  logic               fp_stall;

  int errors = 0;
  int checks = 0;

  int a_int [NREQ];
  int b_int [NREQ];

  int stall_len = 1;
  int wcnt = 0;
  int cyc = 0;

  logic [NREQ-1:0] acc_seen = '0;
  int gid [$];
  int gcyc [$];

  always #5 clk = ~clk;

  fp_sub_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_q     (rsp_q),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .fp_en     (fp_en),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .fp_q      (fp_q),
    .fp_stall  (fp_stall)
  );

  task automatic check_eq(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Integers up to 2047 are exact in FP16.
  function automatic logic [15:0] to_fp16(input int v);
    int mag;
    int p;
    logic s;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    mag = s ? -v : v;
    p = 0;
    for (int k = 0; k < 16; k++) begin
      if ((mag >> k) != 0) p = k;
    end
    return {s, 5'(p + 15), 10'((mag << (10 - p)) & 1023)};
  endfunction

  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    int m;
    int v;
    e = int'(h[14:10]);
    m = 1024 + int'(h[9:0]);
    if (e == 0) return 0;
    v = (e >= 25) ? (m << (e - 25)) : (m >> (25 - e));
    return h[15] ? -v : v;
  endfunction

  function automatic int pick(
    input logic [NREQ-1:0] v,
    input int ptr
  );
    for (int k = 0; k < NREQ; k++) begin
      if (v[IDW'((ptr + k) % NREQ)]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int gq(input int k);
    return (k < gid.size()) ? gid[k] : -1;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign req_a[g*DW +: DW] = to_fp16(a_int[g]);
    assign req_b[g*DW +: DW] = to_fp16(b_int[g]);
  end

  // Wrapper model: stalls stall_len cycles after enable, junk while stalled.
  always @(posedge clk) begin
    wcnt <= fp_en ? wcnt + 1 : 0;
    cyc  <= cyc + 1;
  end

  assign fp_stall = fp_en && (wcnt < stall_len);
  assign fp_q = fp_stall ? 16'h7E00 :
    to_fp16(fp16_to_int(fp_a) - fp16_to_int(fp_b));

  // Reference: an accepted op owns the unit until its response cycle.
  int m_ptr = 0;
  int m_acc = -10;
  int m_rsp = -10;
  int m_free = 0;
  int m_id = 0;
  int m_ai = 0;
  int m_bi = 0;
  logic [DW-1:0] m_q = '0;
  int m_rid = 0;

  always @(negedge clk) begin
    int w;
    bit idle;
    bit in_exec;
    bit in_rsp;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    acc_seen = req_ready;
    for (int k = 0; k < NREQ; k++) begin
      if (req_ready[k]) begin
        gid.push_back(k);
        gcyc.push_back(cyc);
      end
    end
    if (!reset) begin
      check_eq("rst_ready", req_ready, '0);
      m_ptr = 0;
      m_acc = -10;
      m_rsp = -10;
      m_free = cyc + 1;
      m_q = '0;
      m_rid = 0;
    end else begin
      idle = (cyc >= m_free);
      in_exec = (cyc > m_acc) && (cyc < m_rsp);
      in_rsp = (cyc == m_rsp);
      exp_rdy = '0;
      w = -1;
      if (idle) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) exp_rdy[IDW'(w)] = 1'b1;
      end
      exp_rv = '0;
      if (in_rsp) begin
        exp_rv[IDW'(m_id)] = 1'b1;
        m_q = to_fp16(m_ai - m_bi);
        m_rid = m_id;
      end
      check_eq("req_ready", req_ready, exp_rdy);
      check_eq("busy", busy, !idle);
      check_eq("fp_en", fp_en, in_exec);
      check_eq("rsp_valid", rsp_valid, exp_rv);
      check_eq("rsp_q", rsp_q, m_q);
      check_eq("rsp_id", rsp_id, m_rid);
      if (in_exec) begin
        check_eq("fp_a", fp_a, to_fp16(m_ai));
        check_eq("fp_b", fp_b, to_fp16(m_bi));
      end
      if (w >= 0) begin
        m_acc = cyc;
        m_rsp = cyc + stall_len + 2;
        m_free = m_rsp + 1;
        m_id = w;
        m_ai = a_int[w];
        m_bi = b_int[w];
        m_ptr = (w + 1) % NREQ;
      end
    end
  end

  task automatic new_op(input int i);
    a_int[i] = int'($urandom_range(0, 1000));
    b_int[i] = int'($urandom_range(0, 1000));
  endtask

  task automatic rand_cycle(input bit cont);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_seen[i]) begin
        new_op(i);
        req_valid[i] = cont ? 1'b1 : 1'($urandom_range(0, 1));
      end else if (!req_valid[i]) begin
        if (cont || $urandom_range(0, 3) == 0) begin
          new_op(i);
          req_valid[i] = 1'b1;
        end
      end else if (!cont && $urandom_range(0, 15) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int n);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [NREQ-1:0] m, input int maxc);
    @(posedge clk);
    #1;
    req_valid = m;
    for (int n = 0; n < maxc && req_valid != '0; n++) begin
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc_seen;
    end
    check_eq("serve_done", req_valid, '0);
    req_valid = '0;
  endtask

  initial begin
    int n;
    int n_en;
    int rsp_at;
    for (int i = 0; i < NREQ; i++) new_op(i);

    // All four requesting continuously out of reset.
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    while (gid.size() < 5 && n < 40) begin
      rand_cycle(1'b1);
      n++;
    end
    drain(8);
    check_eq("cont_g0", gq(0), 0);
    check_eq("cont_g1", gq(1), 1);
    check_eq("cont_g2", gq(2), 2);
    check_eq("cont_g3", gq(3), 3);
    check_eq("cont_g4", gq(4), 0);
    for (int k = 1; k < 5; k++) begin
      if (k < gcyc.size())
        check_eq("cont_gap", gcyc[k] - gcyc[k-1], 4);
      else
        check_eq("cont_gap", 0, 4);
    end

    // Single request: 3.0 - 1.0 on requester 2.
    @(posedge clk);
    #1;
    a_int[2] = 3;
    b_int[2] = 1;
    req_valid = 4'b0100;
    @(negedge clk);
    check_eq("single_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    check_eq("single_rv", rsp_valid, 4'b0100);
    check_eq("single_q", rsp_q, 16'h4000);
    check_eq("single_id", rsp_id, 2);
    drain(4);

    // Fairness: serve 3, then 0 and 3 together.
    serve(4'b1000, 20);
    drain(6);
    gid.delete();
    gcyc.delete();
    serve(4'b1001, 20);
    drain(6);
    check_eq("fair_first", gq(0), 0);
    check_eq("fair_second", gq(1), 3);

    // Operand stability: requester 1 changes a after acceptance.
    @(posedge clk);
    #1;
    a_int[1] = 10;
    b_int[1] = 4;
    req_valid = 4'b0010;
    @(negedge clk);
    check_eq("stab_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    a_int[1] = 500;
    @(negedge clk);
    check_eq("stab_fp_a", fp_a, 16'h4900);
    repeat (2) @(negedge clk);
    check_eq("stab_q", rsp_q, 16'h4600);
    check_eq("stab_rv", rsp_valid, 4'b0010);
    drain(4);

    // Reset while EXEC: grant 2 moves ptr to 3, reset must clear it.
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    @(negedge clk);
    check_eq("rst_acc", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_fp_en", fp_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rv", rsp_valid, '0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    @(negedge clk);
    check_eq("rst_ptr0", req_ready, 4'b0010);
    drain(8);

    // Wrapper stalls three cycles.
    stall_len = 3;
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check_eq("stall_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    n_en = 0;
    rsp_at = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (fp_en) n_en++;
      if (rsp_valid[0]) rsp_at = k;
    end
    check_eq("stall_en_cycles", n_en, 4);
    check_eq("stall_rsp_at", rsp_at, 5);
    drain(6);

    // Random traffic at several stall lengths.
    for (int s = 1; s <= 3; s++) begin
      stall_len = s;
      repeat (250) rand_cycle(1'b0);
      drain(10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
